// File: rtl/cpu_pkg.sv
// Shared constants for the basic processor control path: opcodes, FSM state encodings, ALU selects.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_pkg;

  // Opcode field of the IR (upper bits). 110 is reserved; 111 is reserved or HALT.
  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_BNE   = 3'b100;
  localparam logic [2:0] OP_XOR   = 3'b101;
  localparam logic [2:0] OP_RSVD  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // Sequencer state encodings.
  typedef logic [3:0] state_t;
  localparam state_t ST_FETCH_ADDR = 4'd0;
  localparam state_t ST_FETCH_READ = 4'd1;
  localparam state_t ST_FETCH_IR   = 4'd2;
  localparam state_t ST_DECODE     = 4'd3;
  localparam state_t ST_STORE_WR   = 4'd4;
  localparam state_t ST_OPER_READ  = 4'd5;
  localparam state_t ST_EXEC       = 4'd6;
  localparam state_t ST_BRANCH     = 4'd7;
  localparam state_t ST_HALT       = 4'd8;

  // ALU operation selects.
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_XOR  = 2'b11;

endpackage

// File: rtl/sequencer.sv
// Moore fetch/decode/execute sequencer driving every load/bus strobe on the sysbus; SEQ_HALT_EN adds a HALT state for op=111.
// Latency: strobes are a combinational decode of the current state; LOAD/ADD/SUB/XOR 6 cycles, STORE/BNE 5, reserved 4.
// Backpressure: none; the FSM advances every cycle and only stops in HALT (cleared by n_reset).
module sequencer
  import cpu_pkg::*;
#(
  parameter int OP_W  = 3,
  parameter int ALU_W = 2
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [OP_W-1:0]  op,
  input  logic             z_flag,
  output logic             PC_bus,
  output logic             load_PC,
  output logic             INC_PC,
  output logic             load_IR,
  output logic             Addr_bus,
  output logic             load_MAR,
  output logic             MDR_bus,
  output logic             load_MDR,
  output logic             CS,
  output logic             R_NW,
  output logic             ACC_bus,
  output logic             load_ACC,
  output logic [ALU_W-1:0] alu_op,
  output logic             halted
);

  state_t state_q;
  state_t state_d;

  // Next-state logic: op is looked at only in DECODE, z_flag is never needed for sequencing.
  always_comb begin
    state_d = ST_FETCH_ADDR;
    case (state_q)
      ST_FETCH_ADDR: state_d = ST_FETCH_READ;
      ST_FETCH_READ: state_d = ST_FETCH_IR;
      ST_FETCH_IR:   state_d = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_W'(OP_STORE)) begin
          state_d = ST_STORE_WR;
        end else if (op == OP_W'(OP_BNE)) begin
          state_d = ST_BRANCH;
        end else if (op == OP_W'(OP_LOAD) || op == OP_W'(OP_ADD) ||
                     op == OP_W'(OP_SUB)  || op == OP_W'(OP_XOR)) begin
          state_d = ST_OPER_READ;
`ifdef SEQ_HALT_EN
        end else if (op == OP_W'(OP_HALT)) begin
          state_d = ST_HALT;
`endif
        end else begin
          state_d = ST_FETCH_ADDR;
        end
      end
      ST_STORE_WR:   state_d = ST_FETCH_ADDR;
      ST_OPER_READ:  state_d = ST_EXEC;
      ST_EXEC:       state_d = ST_FETCH_ADDR;
      ST_BRANCH:     state_d = ST_FETCH_ADDR;
`ifdef SEQ_HALT_EN
      ST_HALT:       state_d = ST_HALT;
`endif
      default:       state_d = ST_FETCH_ADDR;
    endcase
  end

  // State register; reset parks the machine at the start of instruction fetch.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_FETCH_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode; everything is held low while n_reset is asserted so a partial STORE cannot complete.
  always_comb begin
    PC_bus   = 1'b0;
    load_PC  = 1'b0;
    INC_PC   = 1'b0;
    load_IR  = 1'b0;
    Addr_bus = 1'b0;
    load_MAR = 1'b0;
    MDR_bus  = 1'b0;
    load_MDR = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b0;
    ACC_bus  = 1'b0;
    load_ACC = 1'b0;
    alu_op   = ALU_W'(ALU_PASS);
    halted   = 1'b0;
    if (n_reset) begin
      case (state_q)
        ST_FETCH_ADDR: begin
          PC_bus   = 1'b1;
          load_MAR = 1'b1;
          INC_PC   = 1'b1;
          load_PC  = 1'b1;
        end
        ST_FETCH_READ: begin
          CS   = 1'b1;
          R_NW = 1'b1;
        end
        ST_FETCH_IR: begin
          MDR_bus = 1'b1;
          load_IR = 1'b1;
        end
        ST_DECODE: begin
          Addr_bus = 1'b1;
          load_MAR = 1'b1;
        end
        ST_STORE_WR: begin
          ACC_bus  = 1'b1;
          load_MDR = 1'b1;
          CS       = 1'b1;
          R_NW     = 1'b0;
        end
        ST_OPER_READ: begin
          CS   = 1'b1;
          R_NW = 1'b1;
        end
        ST_EXEC: begin
          MDR_bus  = 1'b1;
          load_ACC = 1'b1;
          if (op == OP_W'(OP_ADD)) begin
            alu_op = ALU_W'(ALU_ADD);
          end else if (op == OP_W'(OP_SUB)) begin
            alu_op = ALU_W'(ALU_SUB);
          end else if (op == OP_W'(OP_XOR)) begin
            alu_op = ALU_W'(ALU_XOR);
          end else begin
            alu_op = ALU_W'(ALU_PASS);
          end
        end
        ST_BRANCH: begin
          // Branch on not-zero: the IR address field becomes the next PC.
          if (!z_flag) begin
            Addr_bus = 1'b1;
            load_PC  = 1'b1;
          end
        end
`ifdef SEQ_HALT_EN
        ST_HALT: begin
          halted = 1'b1;
        end
`endif
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for the sequencer: expected strobe vectors are queued per cycle and compared mid-cycle.
// Latency: checks each state one cycle apart, sampled 1 time unit after the falling edge.
// Backpressure: n/a.
module tb_sequencer;

  logic       clock;
  logic       n_reset;
  logic [2:0] op;
  logic       z_flag;
  logic       PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR;
  logic       MDR_bus, load_MDR, CS, R_NW, ACC_bus, load_ACC, halted;
  logic [1:0] alu_op;

  sequencer #(.OP_W(3), .ALU_W(2)) dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .op       (op),
    .z_flag   (z_flag),
    .PC_bus   (PC_bus),
    .load_PC  (load_PC),
    .INC_PC   (INC_PC),
    .load_IR  (load_IR),
    .Addr_bus (Addr_bus),
    .load_MAR (load_MAR),
    .MDR_bus  (MDR_bus),
    .load_MDR (load_MDR),
    .CS       (CS),
    .R_NW     (R_NW),
    .ACC_bus  (ACC_bus),
    .load_ACC (load_ACC),
    .alu_op   (alu_op),
    .halted   (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed vector: {PC_bus,load_PC,INC_PC,load_IR,Addr_bus,load_MAR, MDR_bus,load_MDR,CS,R_NW,ACC_bus,load_ACC, alu_op, halted}
  logic [14:0] obs;
  assign obs = {PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR,
                MDR_bus, load_MDR, CS, R_NW, ACC_bus, load_ACC, alu_op, halted};

  localparam logic [14:0] E_ZERO = 15'b000000_000000_00_0;
  localparam logic [14:0] E_FA   = 15'b111001_000000_00_0;
  localparam logic [14:0] E_FR   = 15'b000000_001100_00_0;
  localparam logic [14:0] E_FI   = 15'b000100_100000_00_0;
  localparam logic [14:0] E_DEC  = 15'b000011_000000_00_0;
  localparam logic [14:0] E_ST   = 15'b000000_011010_00_0;
  localparam logic [14:0] E_OR   = 15'b000000_001100_00_0;
  localparam logic [14:0] E_BRT  = 15'b010010_000000_00_0;
  localparam logic [14:0] E_HALT = 15'b000000_000000_00_1;

  function automatic logic [14:0] e_exec(input logic [1:0] alu);
    return {12'b000000_100001, alu, 1'b0};
  endfunction

  logic [14:0] sb[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Queue the expectation, let combinational outputs settle, compare, optionally move to the next cycle.
  task automatic chk(input logic [14:0] exp, input string tag, input bit adv);
    logic [14:0] e;
    string       t;
    sb.push_back(exp);
    tag_q.push_back(tag);
    #1;
    e = sb.pop_front();
    t = tag_q.pop_front();
    n_vec++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
    if (adv) @(negedge clock);
  endtask

  // Fetch plus decode, with op presented before DECODE resolves.
  task automatic fetch(input logic [2:0] opc, input string tag);
    chk(E_FA, {tag, "_fetch_addr"}, 1'b1);
    chk(E_FR, {tag, "_fetch_read"}, 1'b1);
    op = opc;
    chk(E_FI, {tag, "_fetch_ir"}, 1'b1);
    chk(E_DEC, {tag, "_decode"}, 1'b1);
  endtask

  initial begin
    n_reset = 1'b0;
    op      = 3'b000;
    z_flag  = 1'b0;

    // Reset held for two cycles: every output low, even though the state is FETCH_ADDR.
    @(negedge clock);
    chk(E_ZERO, "reset_c0", 1'b1);
    chk(E_ZERO, "reset_c1", 1'b0);
    n_reset = 1'b1;

    // LOAD: six cycles, back to FETCH_ADDR afterwards.
    fetch(3'b000, "load");
    chk(E_OR, "load_oper_read", 1'b1);
    chk(e_exec(2'b00), "load_exec", 1'b1);

    // XOR, ADD, SUB: ALU select seen only in EXEC.
    fetch(3'b101, "xor");
    chk(E_OR, "xor_oper_read", 1'b1);
    chk(e_exec(2'b11), "xor_exec", 1'b1);
    fetch(3'b010, "add");
    chk(E_OR, "add_oper_read", 1'b1);
    chk(e_exec(2'b01), "add_exec", 1'b1);
    fetch(3'b011, "sub");
    chk(E_OR, "sub_oper_read", 1'b1);
    chk(e_exec(2'b10), "sub_exec", 1'b1);

    // STORE: five cycles, write strobe with R_NW low.
    fetch(3'b001, "store");
    chk(E_ST, "store_wr", 1'b1);

    // BNE taken then not taken.
    z_flag = 1'b0;
    fetch(3'b100, "bne_taken");
    chk(E_BRT, "bne_taken_branch", 1'b1);
    z_flag = 1'b1;
    fetch(3'b100, "bne_not_taken");
    chk(E_ZERO, "bne_not_taken_branch", 1'b1);
    z_flag = 1'b0;

    // Reserved 110: four cycles.
    fetch(3'b110, "rsvd110");

    // Mid-instruction reset during OPER_READ: outputs drop without a clock edge.
    fetch(3'b010, "midrst");
    chk(E_OR, "midrst_oper_read", 1'b0);
    #2;
    n_reset = 1'b0;
    chk(E_ZERO, "midrst_async_zero", 1'b1);
    chk(E_ZERO, "midrst_held", 1'b0);
    n_reset = 1'b1;

    // Opcode 111: HALT when enabled, otherwise reserved.
`ifdef SEQ_HALT_EN
    fetch(3'b111, "halt");
    op = 3'b000;
    for (int i = 0; i < 20; i++) chk(E_HALT, "halt_hold", 1'b1);
    n_reset = 1'b0;
    chk(E_ZERO, "halt_reset", 1'b1);
    n_reset = 1'b1;
    chk(E_FA, "halt_exit_fetch", 1'b1);
`else
    fetch(3'b111, "rsvd111");
    chk(E_FA, "rsvd111_next_fetch", 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sequencer.md
Name: sequencer

Overview:
- Moore control unit for the basic processor; directly upstream of the ROM, RAM, PC, IR, ACC and ALU on the shared sysbus.
- Decodes the IR opcode and steps a fetch/decode/execute state machine.
- Drives every load/bus-enable strobe, including ROM load_MAR, MDR_bus, CS and R_NW.

Parameters:
- OP_W, 3, opcode width (IR upper bits).
- ALU_W, 2, width of ALU operation select.

Ports:
- clock  input  1  system clock, all state changes on rising edge.
- n_reset  input  1  asynchronous active-low reset.
- op  input  OP_W  opcode field from IR.
- z_flag  input  1  accumulator-zero flag from ALU.
- PC_bus  output  1  PC drives sysbus.
- load_PC  output  1  PC loads next value.
- INC_PC  output  1  PC next value = PC+1 (else sysbus).
- load_IR  output  1  IR loads from sysbus.
- Addr_bus  output  1  IR address field drives sysbus.
- load_MAR  output  1  ROM/RAM MAR loads from sysbus.
- MDR_bus  output  1  memory MDR drives sysbus.
- load_MDR  output  1  RAM MDR loads from sysbus.
- CS  output  1  memory chip select.
- R_NW  output  1  1 = read, 0 = write (valid when CS=1).
- ACC_bus  output  1  ACC drives sysbus.
- load_ACC  output  1  ACC loads ALU result.
- alu_op  output  ALU_W  00 pass, 01 add, 10 sub, 11 xor.
- halted  output  1  sequencer stopped (see Optional Feature).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clock, n_reset). Reset sets the state to FETCH_ADDR. While n_reset=0, all outputs are forced to 0 (alu_op=00, halted=0).
- Outputs: combinational decode of the registered state (plus op/z_flag where noted). No output depends on sysbus.
- States, with asserted outputs and next state:
  - FETCH_ADDR: PC_bus, load_MAR, INC_PC, load_PC -> FETCH_READ.
  - FETCH_READ: CS, R_NW -> FETCH_IR.
  - FETCH_IR: MDR_bus, load_IR -> DECODE.
  - DECODE: Addr_bus, load_MAR. Next state by op:
    - STORE -> STORE_WR
    - BNE -> BRANCH
    - LOAD/ADD/SUB/XOR -> OPER_READ
    - reserved -> FETCH_ADDR
  - STORE_WR: ACC_bus, load_MDR, CS, R_NW=0 -> FETCH_ADDR.
  - OPER_READ: CS, R_NW=1 -> EXEC.
  - EXEC: MDR_bus, load_ACC; alu_op = 00 for LOAD, 01 ADD, 10 SUB, 11 XOR -> FETCH_ADDR.
  - BRANCH: if z_flag=0 then Addr_bus, load_PC (INC_PC=0); if z_flag=1 no strobes. -> FETCH_ADDR.
- Latency:
  - LOAD/ADD/SUB/XOR: 6 cycles.
  - STORE: 5 cycles.
  - BNE: 5 cycles.
  - Reserved opcode: 4 cycles.
- Mutual exclusion: at most one bus driver (PC_bus, Addr_bus, MDR_bus, ACC_bus) high in any state.
- Sampling: op is sampled only in DECODE and EXEC. z_flag is sampled only in BRANCH.
- Reset asserted mid-instruction: immediate return to FETCH_ADDR with all strobes low. Any partial STORE is abandoned.
- alu_op = 00 in every state except EXEC.

Optional Feature:
- Macro: SEQ_HALT_EN.
- Defined: op=111 in DECODE -> HALT. HALT drives all strobes 0 and halted=1, and stays there until n_reset is asserted.
- Undefined: 111 is reserved (DECODE -> FETCH_ADDR) and halted is tied 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants: LOAD=000, STORE=001, ADD=010, SUB=011, BNE=100, XOR=101, reserved 110, 111 (HALT when enabled)
  - state_t enum
  - alu_op constants
- Single module; no sub-module is natural.

Test Plan:
- Reset check: n_reset low for 2 cycles, release -> all outputs 0 during reset. First active cycle shows PC_bus=load_MAR=INC_PC=load_PC=1.
- LOAD: op=000 -> 6-cycle sequence. EXEC cycle shows MDR_bus=load_ACC=1, alu_op=00, then back in FETCH_ADDR.
- XOR then STORE: op=101 -> EXEC shows alu_op=11. Then op=001 -> STORE_WR shows ACC_bus=load_MDR=CS=1, R_NW=0; instruction takes 5 cycles.
- BNE taken/not taken: op=100 with z_flag=0 -> BRANCH shows Addr_bus=load_PC=1, INC_PC=0. With z_flag=1 -> all strobes 0.
- Mid-instruction reset: assert n_reset during OPER_READ -> outputs drop to 0 asynchronously, restart at FETCH_ADDR.
- op=111: with SEQ_HALT_EN, halted=1 persists 20 cycles with strobes 0. Without it, op=111 -> FETCH_ADDR after DECODE (4 cycles).
